// File: rtl/pipelined_addsub_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_addsub_pkg
//   Shared definitions for the pipelined add/subtract unit and its carry-skip
//   slices: operation encoding, default geometry and the half-width rule that
//   splits the carry chain between the two pipeline stages.
// -----------------------------------------------------------------------------
package pipelined_addsub_pkg;

    // Operation select carried alongside each operand beat.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_BLOCK = 4;

    // The carry chain is cut in the middle: the low half resolves in stage 1,
    // the high half in stage 2.
    function automatic int half_width(input int width);
        return width / 2;
    endfunction

endpackage : pipelined_addsub_pkg

// File: rtl/pipelined_addsub_cs_adder_slice.sv
// -----------------------------------------------------------------------------
// cs_adder_slice
//   Combinational W-bit carry-skip adder built from W/BLOCK ripple blocks.
//   A block whose bits all propagate forwards its carry-in directly to the next
//   block, bypassing its own ripple chain.
//
//   Parameters
//     W      slice width
//     BLOCK  ripple block size, must divide W
//   Ports
//     a, b   [W-1:0]  addends
//     cin             carry into bit 0
//     sum    [W-1:0]  a + b + cin (low W bits)
//     cout            carry out of bit W-1
// -----------------------------------------------------------------------------
module cs_adder_slice
    import pipelined_addsub_pkg::*;
#(
    parameter int W     = half_width(DEFAULT_WIDTH),
    parameter int BLOCK = DEFAULT_BLOCK
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int NB = W / BLOCK;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : blk
            logic [BLOCK-1:0] a_blk;
            logic [BLOCK-1:0] b_blk;
            logic [BLOCK-1:0] s_blk;
            logic             cin_blk;
            logic             ripple_cout;
            logic             skip;
            logic             cout_blk;

            assign a_blk = a[gi*BLOCK +: BLOCK];
            assign b_blk = b[gi*BLOCK +: BLOCK];

            // Each block takes its carry from the previous block's skip mux,
            // so the long path is one ripple block plus a chain of muxes.
            if (gi == 0) begin : g_first
                assign cin_blk = cin;
            end else begin : g_rest
                assign cin_blk = blk[gi-1].cout_blk;
            end

            always_comb begin
                logic c;
                c     = cin_blk;
                s_blk = '0;
                for (int j = 0; j < BLOCK; j++) begin
                    s_blk[j] = a_blk[j] ^ b_blk[j] ^ c;
                    c        = (a_blk[j] & b_blk[j]) | ((a_blk[j] ^ b_blk[j]) & c);
                end
                ripple_cout = c;
            end

            assign skip     = &(a_blk ^ b_blk);
            assign cout_blk = skip ? cin_blk : ripple_cout;

            assign sum[gi*BLOCK +: BLOCK] = s_blk;
        end
    endgenerate

    assign cout = blk[NB-1].cout_blk;

endmodule : cs_adder_slice

// File: rtl/pipelined_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_addsub
//   Two-stage pipelined add/subtract unit with valid/ready handshakes on both
//   sides. Stage 1 resolves the low half of the carry chain, stage 2 the high
//   half plus the flags. One beat per cycle is sustained under backpressure and
//   an empty stage 2 always pulls stage 1 forward.
//
//   Parameters
//     WIDTH  operand/result width (even, >= 8)
//     BLOCK  carry-skip block size (divides WIDTH/2)
//   Ports
//     clk, rst              clock, asynchronous active-high reset
//     in_valid / in_ready   operand handshake
//     in_op                 0 = add, 1 = subtract
//     in_a, in_b, in_cin    operands; in_cin is the borrow-in for subtract
//     out_valid / out_ready result handshake
//     out_sum               result
//     out_cout              carry-out (add) or borrow-out (subtract)
//     out_ovf               signed two's-complement overflow
//     out_zero              out_sum == 0 (meaningful only with out_valid)
// -----------------------------------------------------------------------------
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int BLOCK = DEFAULT_BLOCK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int HALF = half_width(WIDTH);

    // ---------------------------------------------------------------- handshake
    logic adv1;
    logic adv2;

    // ------------------------------------------------------- stage 1 registers
    logic            s1_valid_reg;
    logic [HALF-1:0] s1_sum_lo_reg;
    logic            s1_carry_reg;
    logic [HALF-1:0] s1_a_hi_reg;
    logic [HALF-1:0] s1_b_hi_reg;
    op_e             s1_op_reg;

    // ------------------------------------------------------- stage 2 registers
    logic             s2_valid_reg;
    logic [WIDTH-1:0] s2_sum_reg;
    logic             s2_cout_reg;
    logic             s2_ovf_reg;
    logic             s2_zero_reg;

    // ---------------------------------------------------- stage 1 combinational
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [HALF-1:0]  sum_lo_next;
    logic             carry_lo_next;

    // ---------------------------------------------------- stage 2 combinational
    logic [HALF-1:0]  sum_hi_next;
    logic             carry_hi_next;
    logic [WIDTH-1:0] sum_next;
    logic             cout_next;
    logic             ovf_next;
    logic             zero_next;

    // Stage 2 frees up whenever it is empty or its result is taken; stage 1
    // frees up whenever it is empty or stage 2 frees up.
    assign adv2     = !s2_valid_reg || out_ready;
    assign adv1     = !s1_valid_reg || adv2;
    assign in_ready = adv1;

    // Subtraction is A + ~B + ~borrow_in; inverting B and cin here keeps both
    // stages a plain adder.
    assign b_eff   = (in_op == OP_SUB) ? ~in_b : in_b;
    assign cin_eff = (in_op == OP_SUB) ? ~in_cin : in_cin;

    cs_adder_slice #(
        .W     (HALF),
        .BLOCK (BLOCK)
    ) u_slice_lo (
        .a    (in_a[HALF-1:0]),
        .b    (b_eff[HALF-1:0]),
        .cin  (cin_eff),
        .sum  (sum_lo_next),
        .cout (carry_lo_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_sum_lo_reg <= '0;
            s1_carry_reg  <= 1'b0;
            s1_a_hi_reg   <= '0;
            s1_b_hi_reg   <= '0;
            s1_op_reg     <= OP_ADD;
        end else if (adv1) begin
            s1_valid_reg  <= in_valid;
            s1_sum_lo_reg <= sum_lo_next;
            s1_carry_reg  <= carry_lo_next;
            s1_a_hi_reg   <= in_a[WIDTH-1:HALF];
            s1_b_hi_reg   <= b_eff[WIDTH-1:HALF];
            s1_op_reg     <= op_e'(in_op);
        end
    end

    cs_adder_slice #(
        .W     (HALF),
        .BLOCK (BLOCK)
    ) u_slice_hi (
        .a    (s1_a_hi_reg),
        .b    (s1_b_hi_reg),
        .cin  (s1_carry_reg),
        .sum  (sum_hi_next),
        .cout (carry_hi_next)
    );

    assign sum_next  = {sum_hi_next, s1_sum_lo_reg};
    // Borrow-out is the inverse of the adder carry when subtracting.
    assign cout_next = (s1_op_reg == OP_SUB) ? ~carry_hi_next : carry_hi_next;
    // Overflow: operands (after B inversion) share a sign the result lacks.
    assign ovf_next  = (s1_a_hi_reg[HALF-1] == s1_b_hi_reg[HALF-1])
                    && (sum_hi_next[HALF-1] != s1_a_hi_reg[HALF-1]);
    assign zero_next = ~|sum_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_sum_reg   <= '0;
            s2_cout_reg  <= 1'b0;
            s2_ovf_reg   <= 1'b0;
            s2_zero_reg  <= 1'b0;
        end else if (adv2) begin
            s2_valid_reg <= s1_valid_reg;
            s2_sum_reg   <= sum_next;
            s2_cout_reg  <= cout_next;
            s2_ovf_reg   <= ovf_next;
            s2_zero_reg  <= zero_next;
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_sum   = s2_sum_reg;
    assign out_cout  = s2_cout_reg;
    assign out_ovf   = s2_ovf_reg;
    assign out_zero  = s2_zero_reg;

endmodule : pipelined_addsub

// File: tb/tb_pipelined_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipelined_addsub
//   Directed vector table, streaming/stall and mid-flight reset sequences, and
//   a randomised run against an arithmetic reference model with a scoreboard.
// -----------------------------------------------------------------------------
module tb_pipelined_addsub;

    typedef struct {
        logic        op;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_op;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        out_zero;

    int   checks = 0;
    int   passes = 0;
    int   ntx    = 0;
    res_t exp_q[$];
    logic        held_valid = 1'b0;
    logic [67:0] held       = '0;

    localparam int NV = 10;
    vec_t vecs[NV];
    vec_t idle;

    pipelined_addsub #(
        .WIDTH (64),
        .BLOCK (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Reference: exact signed and unsigned arithmetic in wider precision.
    function automatic vec_t model(input logic op, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin);
        vec_t               r;
        logic signed [65:0] sa;
        logic signed [65:0] sb;
        logic        [65:0] exact;
        logic        [64:0] wide;
        r.op  = op;
        r.a   = a;
        r.b   = b;
        r.cin = cin;
        sa = {{2{a[63]}}, a};
        sb = {{2{b[63]}}, b};
        if (op) begin
            exact  = sa - sb - 66'(cin);
            r.cout = ({1'b0, a} < ({1'b0, b} + 65'(cin)));
        end else begin
            exact  = sa + sb + 66'(cin);
            wide   = {1'b0, a} + {1'b0, b} + 65'(cin);
            r.cout = wide[64];
        end
        r.sum  = exact[63:0];
        r.ovf  = !(exact[65:63] == 3'b000 || exact[65:63] == 3'b111);
        r.zero = (r.sum == 64'd0);
        return r;
    endfunction

    // One clock cycle: drive at negedge, sample 1 time unit later, score.
    task automatic step(input logic v, input vec_t t, input logic rdy, output logic accepted);
        res_t e;
        @(negedge clk);
        in_valid  = v;
        in_op     = t.op;
        in_a      = t.a;
        in_b      = t.b;
        in_cin    = t.cin;
        out_ready = rdy;
        #1;
        // Two beats in flight means both stages are full.
        check("in_ready", {67'd0, in_ready}, {67'd0, !(exp_q.size() == 2 && !rdy)});
        if (held_valid)
            check("stall_hold", {out_valid, out_sum, out_cout, out_ovf, out_zero}, held);
        accepted = v && in_ready;
        if (out_valid && rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL spurious_result: got sum %h, expected no result", out_sum);
            end else begin
                e = exp_q.pop_front();
                ntx++;
                check("result", {1'b0, out_sum, out_cout, out_ovf, out_zero},
                      {1'b0, e.sum, e.cout, e.ovf, e.zero});
                $display("txn %0d: sum=%h cout=%b ovf=%b zero=%b", ntx, out_sum, out_cout,
                         out_ovf, out_zero);
            end
        end
        held_valid = out_valid && !rdy;
        held       = {out_valid, out_sum, out_cout, out_ovf, out_zero};
        if (accepted) exp_q.push_back('{sum: t.sum, cout: t.cout, ovf: t.ovf, zero: t.zero});
    endtask

    initial begin
        logic acc;
        logic stall_seen;
        int   idx;
        int   n_acc;
        vec_t t;
        logic [63:0] ra;
        logic [63:0] rb;

        //       op    a                      b                      cin   sum                    cout  ovf   zero
        vecs[0] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                 1'b0, 64'h0,                 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 64'h5,                 64'h7,                 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1,                 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 64'h7,                 64'h5,                 1'b0, 64'h2,                 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 64'h8000_0000_0000_0000, 64'h1,                 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 64'h1,                 64'h1,                 1'b1, 64'h3,                 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 64'h5,                 64'h5,                 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 64'h5,                 64'h5,                 1'b0, 64'h0,                 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0,                 1'b1, 1'b1, 1'b1};
        vecs[9] = '{1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1,                 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0};
        idle    = '{1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
        out_ready = 1'b0;

        // Reset state, with out_ready low to show in_ready does not depend on it.
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", {out_valid, out_sum, out_cout, out_ovf, out_zero}, 68'd0);
        check("reset_in_ready", {67'd0, in_ready}, 68'd1);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors, one at a time, with latency checks.
        for (int i = 0; i < NV; i++) begin
            step(1'b1, vecs[i], 1'b1, acc);
            check("accept", {67'd0, acc}, 68'd1);
            step(1'b0, idle, 1'b1, acc);
            check("lat_edge1_valid", {67'd0, out_valid}, 68'd0);
            step(1'b0, idle, 1'b1, acc);
            check("lat_edge2_valid", {67'd0, out_valid}, 68'd1);
        end

        // Stream 8 beats with out_ready held low on cycles 3..5.
        idx = 0;
        stall_seen = 1'b0;
        for (int k = 0; k < 40 && (idx < 8 || exp_q.size() > 0); k++) begin
            step(idx < 8, vecs[(idx < 8) ? idx : 0], !(k >= 3 && k <= 5), acc);
            if (!in_ready) stall_seen = 1'b1;
            if (acc) idx++;
        end
        check("stream_drained", {66'd0, idx == 8, exp_q.size() == 0}, 68'd3);
        check("stream_stall_seen", {67'd0, stall_seen}, 68'd1);

        // Reset with two beats in flight, then a fresh beat.
        step(1'b1, vecs[2], 1'b0, acc);
        step(1'b1, vecs[3], 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_outputs", {out_valid, out_sum, out_cout, out_ovf, out_zero}, 68'd0);
        check("midrst_in_ready", {67'd0, in_ready}, 68'd1);
        exp_q.delete();
        held_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, vecs[4], 1'b1, acc);
        check("post_rst_accept", {67'd0, acc}, 68'd1);
        step(1'b0, idle, 1'b1, acc);
        step(1'b0, idle, 1'b1, acc);
        check("post_rst_valid", {67'd0, out_valid}, 68'd1);
        check("post_rst_queue", {36'd0, 32'(exp_q.size())}, 68'd0);

        // Random traffic against the reference model.
        n_acc = 0;
        for (int k = 0; k < 60000 && n_acc < 10000; k++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            case ($urandom_range(0, 7))
                0: rb = ra;
                1: ra = 64'h7FFF_FFFF_FFFF_FFFF;
                2: ra = 64'h8000_0000_0000_0000;
                3: ra = 64'hFFFF_FFFF_FFFF_FFFF;
                default: ;
            endcase
            t = model(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)));
            step($urandom_range(0, 3) != 0, t, $urandom_range(0, 3) != 0, acc);
            if (acc) n_acc++;
        end
        check("rand_accepted", {36'd0, 32'(n_acc)}, 68'd10000);
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) step(1'b0, idle, 1'b1, acc);
        check("rand_drained", {36'd0, 32'(exp_q.size())}, 68'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_pipelined_addsub
